// File: rtl/mips_lsu.sv
// mips_lsu: byte/half/word load-store unit between the MIPS datapath and a variable-latency data memory.
// Latency: accept->rsp_valid is 2 cycles with ack in ISSUE, +1 per WAIT cycle; rejected requests take 1 cycle.
// Backpressure: one access in flight; req_ready only in IDLE, response held until rsp_ready.
module mips_lsu #(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    output logic [3:0]        dmem_be,
    output logic              dmem_wren,
    output logic              dmem_rden,
    input  logic [31:0]       dmem_dout,
    input  logic              dmem_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              sgn;
        logic [ADDR_W+1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        bad_in;
    logic        accessing;
    logic        timeout;
    logic [1:0]  byte_lane;
    logic        hi_half;
    logic [3:0]  be_c;
    logic [31:0] din_c;
    logic [31:0] load_c;
    logic [31:0] lane_shift;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign bad_in = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign accessing = (state_q == ISSUE) || (state_q == WAIT);
    assign timeout   = (cnt_q == 8'(TIMEOUT - 1));

    // Big-endian mirrors the lane of each byte address; MSB-first ordering then keeps halves unswapped on lanes.
    assign byte_lane = BIG_ENDIAN ? ~req_q.addr[1:0] : req_q.addr[1:0];
    assign hi_half   = BIG_ENDIAN ? ~req_q.addr[1] : req_q.addr[1];

    always_comb begin
        be_c   = 4'b1111;
        din_c  = req_q.wdata;
        load_c = dmem_dout;
        lane_shift = dmem_dout >> {byte_lane, 3'b000};
        byte_v = lane_shift[7:0];
        half_v = hi_half ? dmem_dout[31:16] : dmem_dout[15:0];
        case (req_q.size)
            2'b00: begin
                be_c   = 4'b0001 << byte_lane;
                din_c  = {4{req_q.wdata[7:0]}};
                load_c = {{24{req_q.sgn & byte_v[7]}}, byte_v};
            end
            2'b01: begin
                be_c   = hi_half ? 4'b1100 : 4'b0011;
                din_c  = {2{req_q.wdata[15:0]}};
                load_c = {{16{req_q.sgn & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = bad_in ? RESP : ISSUE;
            ISSUE: state_d = dmem_ack ? RESP : WAIT;
            WAIT:  if (dmem_ack || timeout) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_err   = rsp_valid & err_q;
    assign dmem_addr = accessing ? req_q.addr[ADDR_W+1:2] : '0;
    assign dmem_be   = accessing ? be_c : 4'b0000;
    assign dmem_din  = accessing ? din_c : 32'h0;
    assign dmem_wren = accessing & req_q.we;
    assign dmem_rden = accessing & ~req_q.we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid) begin
                    req_q   <= '{we: req_we, size: req_size, sgn: req_signed,
                                 addr: req_addr, wdata: req_wdata};
                    cnt_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= bad_in;
                end
                ISSUE, WAIT: begin
                    if (dmem_ack) begin
                        rdata_q <= req_q.we ? 32'h0 : load_c;
                        err_q   <= 1'b0;
                    end else if (state_q == WAIT) begin
                        if (timeout) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
